acia_fifo_bridge: RTL
=====================

Name: acia_fifo_bridge

Overview:
- Parametrised second-generation ACIA 6551-style virtual UART on the C64/C128 CPU register bus.
- Contains its own RX and TX FIFOs of configurable depth, replacing the external FIFO strobes.
- Uses genuine 6551 status bit positions, with command-register-driven IRQ enables, overrun detection and software reset.
- The Linux side connects via valid/ready streams; the RX flow-control mode is selectable.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of two, minimum 2.
- RX_DEPTH, 16, RX FIFO entries; power of two, minimum 2.
- RX_BACKPRESSURE, 1, 1 = rx_ready deasserts when the RX FIFO is full; 0 = rx_ready is tied to 1 and a push while full is dropped and flags overrun.

Ports:
- clk  in  1  system clock; only clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  2  register select: 0 data, 1 status / soft reset, 2 command, 3 control.
- din  in  8  CPU write data.
- dout  out  8  CPU read data (combinational).
- we  in  1  1 = write, 0 = read.
- en  in  1  access strobe; exactly one cycle per bus access.
- tx_data  out  8  TX FIFO head, toward Linux.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  Linux accepts tx_data.
- rx_data  in  8  byte from Linux.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts rx_data.
- tx_level  out  $clog2(TX_DEPTH+1)  TX occupancy.
- rx_level  out  $clog2(RX_DEPTH+1)  RX occupancy.
- irq_n  out  1  active-low interrupt, registered.

Behaviour:
- Reset (rst high at a clk edge):
  - Both FIFOs empty; command = 0x00, control = 0x00, overrun = 0, last_rx = 0x00.
  - irq_n = 1, tx_valid = 0, tx_level = 0, rx_level = 0.
  - rx_ready = 1 in both modes (RX FIFO empty).
  - Reset mid-transfer discards all FIFO contents.
- Strobes: wr0 = en&we&addr==0; rd0 = en&!we&addr==0; wr1 = en&we&addr==1.
- Full/empty for all push/pop decisions are evaluated at cycle start.
- TX path:
  - wr0 pushes din if TX is not full; if full, the write is silently dropped.
  - A Linux pop in the same cycle does not make room for that write.
  - Linux pop occurs on tx_valid&tx_ready; tx_data is the FIFO head (first-word fall-through).
- RX path:
  - Push occurs on rx_valid&rx_ready. rx_ready = !rx_full when RX_BACKPRESSURE=1, else 1.
  - Mode 0, rx_valid while full: byte dropped, overrun set to 1.
  - Mode 0, push and rd0 in the same cycle while full: push dropped and overrun set; the pop proceeds.
  - rd0 with RX non-empty: pop; last_rx <= head; overrun cleared.
  - rd0 with RX empty: no pop, returns last_rx; overrun cleared.
- Register reads (dout = 0xFF when en=0):
  - addr 0: RX head if non-empty, else last_rx.
  - addr 1: status = {irq, DSR=0, DCD=0, TDRE=!tx_full, RDRF=!rx_empty, overrun, framing=0, parity=0}.
  - addr 2: command.
  - addr 3: control.
- Register writes:
  - addr 2 loads command; addr 3 loads control (stored only, baud ignored).
  - wr1 (soft reset): flush both FIFOs, command[4:0] <= 0 (bits 7:5 kept), overrun <= 0; control and last_rx unchanged. Flush overrides any same-cycle push or pop.
- Command fields:
  - bit0 DTR: 0 masks all IRQs.
  - bit1 RX IRQ disable: 1 = disabled.
  - bits3:2 == 01 enables the TX IRQ; any other value disables it.
  - bits 7:4 are stored only.
- IRQ: irq = cmd[0] & ((!cmd[1] & (RDRF | overrun)) | (cmd[3:2]==01 & TDRE)).
  - Level-sensitive, computed from current state.
  - irq_n <= !irq, registered, giving one cycle of latency.
  - Status bit7 shows the combinational irq.
- Levels: tx_level and rx_level update on the edge after the push/pop; a simultaneous push and pop leaves the level unchanged.

Test Plan:
- Reset then read all four registers -> data 0x00, status 0x10, command 0x00, control 0x00; irq_n=1, rx_ready=1, tx_valid=0.
- 17 writes of 0x41+i to addr 0 with tx_ready=0 (TX_DEPTH=16) -> tx_level=16, status bit4=0, 17th byte absent. Then raise tx_ready -> 0x41..0x50 in order, one per cycle; status bit4 returns to 1.
- RX_BACKPRESSURE=0, push 17 bytes -> rx_level=16, status=0x1C. Read addr 0 -> first byte returned; overrun cleared, status=0x18.
- command=0x01: push one RX byte -> irq_n low one cycle after the level change. Read it -> irq_n high. command=0x07 with TX not full -> irq_n low.
- Soft reset with RX=3, TX=5 and command=0xE5 -> both levels 0, command=0xE0, control unchanged, irq_n=1.
- RX_BACKPRESSURE=1 with RX full -> rx_ready=0. rd0 in the same cycle as rx_valid -> level 15; next cycle rx_ready=1 and the push is accepted.

Source files
------------

// File: rtl/acia_fifo_bridge.sv
// ---------------------------------------------------------------------------
// acia_fifo_bridge
// 6551-style virtual ACIA on the C64/C128 CPU register bus. It has internal
// RX and TX FIFOs. The Linux side connects through valid/ready byte streams.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   addr/din/we/en  CPU register access (one en cycle per access)
//   dout            CPU read data, combinational, 0xFF while en=0
//   tx_data/valid   TX FIFO head toward Linux (first-word fall-through)
//   tx_ready        Linux pops the TX head when high with tx_valid
//   rx_data/valid   byte from Linux
//   rx_ready        bridge accepts rx_data
//   tx_level        TX FIFO occupancy
//   rx_level        RX FIFO occupancy
//   irq_n           registered active-low interrupt
// ---------------------------------------------------------------------------
module acia_fifo_bridge #(
   parameter int TX_DEPTH        = 16,
   parameter int RX_DEPTH        = 16,
   parameter int RX_BACKPRESSURE = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    addr,
   input  logic [7:0]                    din,
   output logic [7:0]                    dout,
   input  logic                          we,
   input  logic                          en,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
   output logic [$clog2(RX_DEPTH+1)-1:0] rx_level,
   output logic                          irq_n
);

   localparam int TAW = $clog2(TX_DEPTH);
   localparam int TLW = $clog2(TX_DEPTH+1);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int RLW = $clog2(RX_DEPTH+1);

   // FIFO storage and bookkeeping
   logic [7:0]     r_tx_mem [TX_DEPTH];
   logic [TAW-1:0] r_tx_wptr, r_tx_rptr;
   logic [TLW-1:0] r_tx_count;
   logic [7:0]     r_rx_mem [RX_DEPTH];
   logic [RAW-1:0] r_rx_wptr, r_rx_rptr;
   logic [RLW-1:0] r_rx_count;

   // Register file
   logic [7:0] r_cmd, r_ctrl, r_last_rx;
   logic       r_overrun, r_irq_n;

   // Bus strobes
   logic w_wr0, w_rd0, w_wr1, w_wr2, w_wr3;
   assign w_wr0 = en &  we & (addr == 2'd0);
   assign w_rd0 = en & !we & (addr == 2'd0);
   assign w_wr1 = en &  we & (addr == 2'd1);
   assign w_wr2 = en &  we & (addr == 2'd2);
   assign w_wr3 = en &  we & (addr == 2'd3);

   // Full/empty come straight from the registered counts, so every push/pop
   // decision uses the state at cycle start. A same-cycle pop never makes
   // room for a push.
   logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   assign w_tx_full  = (r_tx_count == TLW'(TX_DEPTH));
   assign w_tx_empty = (r_tx_count == '0);
   assign w_rx_full  = (r_rx_count == RLW'(RX_DEPTH));
   assign w_rx_empty = (r_rx_count == '0);

   logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_drop;
   assign rx_ready  = (RX_BACKPRESSURE != 0) ? !w_rx_full : 1'b1;
   assign w_tx_push = w_wr0 & !w_tx_full;
   assign w_tx_pop  = tx_ready & !w_tx_empty;
   assign w_rx_push = rx_valid & rx_ready & !w_rx_full;
   // A drop can only occur without backpressure, because rx_ready is low
   // whenever the FIFO is full in backpressure mode.
   assign w_rx_drop = rx_valid & rx_ready & w_rx_full;
   assign w_rx_pop  = w_rd0 & !w_rx_empty;

   logic [7:0] w_rx_head;
   assign w_rx_head = r_rx_mem[r_rx_rptr];

   // Interrupt: DTR gates everything; the TX IRQ is enabled only by cmd[3:2]==01.
   logic w_rdrf, w_tdre, w_irq;
   assign w_rdrf = !w_rx_empty;
   assign w_tdre = !w_tx_full;
   assign w_irq  = r_cmd[0] & ((!r_cmd[1] & (w_rdrf | r_overrun)) |
                               ((r_cmd[3:2] == 2'b01) & w_tdre));

   assign tx_data  = r_tx_mem[r_tx_rptr];
   assign tx_valid = !w_tx_empty;
   assign tx_level = r_tx_count;
   assign rx_level = r_rx_count;
   assign irq_n    = r_irq_n;

   // NOTE: FIFO storage is deliberately not reset. The pointers and counts
   // define validity, so stale contents are never observed. This keeps the
   // arrays as plain RAM without reset fan-out.
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= din;
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data;
   end

   // NOTE: all state uses non-blocking assignments. Every branch therefore
   // sees the cycle-start values, so no race exists between the pointer,
   // count and flag updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_count <= '0;
         r_rx_wptr  <= '0;
         r_rx_rptr  <= '0;
         r_rx_count <= '0;
         r_cmd      <= 8'h00;
         r_ctrl     <= 8'h00;
         r_last_rx  <= 8'h00;
         r_overrun  <= 1'b0;
         r_irq_n    <= 1'b1;
      end else begin
         r_irq_n <= !w_irq;
         if (w_wr2)    r_cmd     <= din;
         if (w_wr3)    r_ctrl    <= din;
         if (w_rx_pop) r_last_rx <= w_rx_head;

         if (w_wr1) begin
            // Soft reset: the flush overrides any same-cycle push or pop.
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
            r_cmd[4:0] <= 5'd0;
            r_overrun  <= 1'b0;
         end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_tx_pop})
               2'b10:   r_tx_count <= r_tx_count + 1'b1;
               2'b01:   r_tx_count <= r_tx_count - 1'b1;
               default: r_tx_count <= r_tx_count;
            endcase

            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
               2'b10:   r_rx_count <= r_rx_count + 1'b1;
               2'b01:   r_rx_count <= r_rx_count - 1'b1;
               default: r_rx_count <= r_rx_count;
            endcase

            // A new overrun outranks the clear caused by a same-cycle data read.
            if (w_rx_drop)  r_overrun <= 1'b1;
            else if (w_rd0) r_overrun <= 1'b0;
         end
      end
   end

   // NOTE: dout gets a default before the case. No path leaves it
   // unassigned, so no latch is inferred.
   always_comb begin
      dout = 8'hFF;
      if (en) begin
         case (addr)
            2'd0:    dout = w_rx_empty ? r_last_rx : w_rx_head;
            2'd1:    dout = {w_irq, 1'b0, 1'b0, w_tdre, w_rdrf, r_overrun, 2'b00};
            2'd2:    dout = r_cmd;
            default: dout = r_ctrl;
         endcase
      end
   end

endmodule
